// File: rtl/ahbl_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_gpio_ctrl
// Description : AHB-Lite slave register block in front of the 16-bit GPIO pad
//               wrapper. Holds output data, direction, pull-up and pull-down
//               registers. Synchronises the pad inputs. Per-pin edge-detect
//               interrupts are ORed into one registered IRQ line.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   SYNC_STAGES  number of synchroniser flops on WGPIODIN (must be >= 2)
//   RESET_DIR    reset value of the DIR register (0 = input)
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS  AHB-Lite address phase (only HADDR[4:2] decoded)
//   HWRITE, HSIZE        transfer direction, size (size ignored)
//   HWDATA, HREADY       write data (data phase), bus ready
//   HREADYOUT, HRESP     always ready, always OKAY
//   HRDATA               read data, combinational in the data phase
//   IRQ                  registered OR of masked interrupt status
//   WGPIODIN             raw pad inputs from the wrapper
//   WGPIODOUT/DIR/PU/PD  output data, output enable, pull-up, pull-down
// Register map (byte offset):
//   0x00 DATA  (R: synchronised input, W: DOUT)   0x04 DIR    0x08 PU
//   0x0C PD    0x10 IM    0x14 IEDGE (1 = rising)  0x18 RIS (W1C)
//   0x1C MIS   (read-only, RIS & IM)
// ============================================================================
module ahbl_gpio_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RESET_DIR   = 16'h0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        IRQ,
  input  logic [15:0] WGPIODIN,
  output logic [15:0] WGPIODOUT,
  output logic [15:0] WGPIODIR,
  output logic [15:0] WGPIOPU,
  output logic [15:0] WGPIOPD
);

  localparam logic [2:0] c_OFF_DATA  = 3'd0;
  localparam logic [2:0] c_OFF_DIR   = 3'd1;
  localparam logic [2:0] c_OFF_PU    = 3'd2;
  localparam logic [2:0] c_OFF_PD    = 3'd3;
  localparam logic [2:0] c_OFF_IM    = 3'd4;
  localparam logic [2:0] c_OFF_IEDGE = 3'd5;
  localparam logic [2:0] c_OFF_RIS   = 3'd6;
  localparam logic [2:0] c_OFF_MIS   = 3'd7;

  // --------------------------------------------------------------------------
  // Address phase capture
  // --------------------------------------------------------------------------
  logic       w_addr_valid;
  logic       r_wr_en;
  logic       r_rd_en;
  logic [2:0] r_offset;

  assign w_addr_valid = HSEL & HREADY & HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_offset <= 3'd0;
    end else begin
      r_wr_en  <= w_addr_valid & HWRITE;
      r_rd_en  <= w_addr_valid & ~HWRITE;
      r_offset <= w_addr_valid ? HADDR[4:2] : 3'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Data phase write decode
  // --------------------------------------------------------------------------
  logic [15:0] w_wdata;
  logic        w_wr_data;
  logic        w_wr_dir;
  logic        w_wr_pu;
  logic        w_wr_pd;
  logic        w_wr_im;
  logic        w_wr_iedge;
  logic        w_wr_ris;

  assign w_wdata    = HWDATA[15:0];
  assign w_wr_data  = r_wr_en && (r_offset == c_OFF_DATA);
  assign w_wr_dir   = r_wr_en && (r_offset == c_OFF_DIR);
  assign w_wr_pu    = r_wr_en && (r_offset == c_OFF_PU);
  assign w_wr_pd    = r_wr_en && (r_offset == c_OFF_PD);
  assign w_wr_im    = r_wr_en && (r_offset == c_OFF_IM);
  assign w_wr_iedge = r_wr_en && (r_offset == c_OFF_IEDGE);
  assign w_wr_ris   = r_wr_en && (r_offset == c_OFF_RIS);

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  logic [15:0] r_dout;
  logic [15:0] r_dir;
  logic [15:0] r_pu;
  logic [15:0] r_pd;
  logic [15:0] r_im;
  logic [15:0] r_iedge;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dout  <= 16'h0000;
      r_dir   <= RESET_DIR;
      r_pu    <= 16'h0000;
      r_pd    <= 16'h0000;
      r_im    <= 16'h0000;
      r_iedge <= 16'h0000;
    end else begin
      if (w_wr_data)  r_dout  <= w_wdata;
      if (w_wr_dir)   r_dir   <= w_wdata;
      if (w_wr_pu)    r_pu    <= w_wdata;
      if (w_wr_pd)    r_pd    <= w_wdata;
      if (w_wr_im)    r_im    <= w_wdata;
      if (w_wr_iedge) r_iedge <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Input synchroniser: stage 0 samples the pads, last stage is the clean view
  // --------------------------------------------------------------------------
  logic [15:0] r_sync [SYNC_STAGES];
  logic [15:0] w_sync;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= 16'h0000;
      end
    end else begin
      r_sync[0] <= WGPIODIN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Edge detect and interrupt status
  // --------------------------------------------------------------------------
  logic [15:0] r_prev;
  logic [15:0] r_ris;
  logic        r_irq;
  logic [15:0] w_rise;
  logic [15:0] w_fall;
  logic [15:0] w_ev;
  logic [15:0] w_w1c;
  logic [15:0] w_ris_next;

  assign w_rise     = w_sync & ~r_prev;
  assign w_fall     = ~w_sync & r_prev;
  assign w_ev       = (r_iedge & w_rise) | (~r_iedge & w_fall);
  assign w_w1c      = w_wr_ris ? w_wdata : 16'h0000;
  // OR-ing the event in after the clear makes a simultaneous set win.
  assign w_ris_next = (r_ris & ~w_w1c) | w_ev;

  // IRQ is taken from the registered RIS/IM, so it follows a RIS set, a RIS
  // clear or an IM unmask by exactly one cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_prev <= 16'h0000;
      r_ris  <= 16'h0000;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= w_sync;
      r_ris  <= w_ris_next;
      r_irq  <= |(r_ris & r_im);
    end
  end

  // --------------------------------------------------------------------------
  // Read data path
  // --------------------------------------------------------------------------
  logic [15:0] w_rdata;

  always_comb begin
    w_rdata = 16'h0000;
    if (r_rd_en) begin
      case (r_offset)
        c_OFF_DATA:  w_rdata = w_sync;
        c_OFF_DIR:   w_rdata = r_dir;
        c_OFF_PU:    w_rdata = r_pu;
        c_OFF_PD:    w_rdata = r_pd;
        c_OFF_IM:    w_rdata = r_im;
        c_OFF_IEDGE: w_rdata = r_iedge;
        c_OFF_RIS:   w_rdata = r_ris;
        c_OFF_MIS:   w_rdata = r_ris & r_im;
        default:     w_rdata = 16'h0000;
      endcase
    end
  end

  // Address bits outside [4:2], the size and the upper write data are ignored.
  logic w_unused_bits;
  assign w_unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:16]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign HRDATA    = {16'h0000, w_rdata};
  assign IRQ       = r_irq;
  assign WGPIODOUT = r_dout;
  assign WGPIODIR  = r_dir;
  assign WGPIOPU   = r_pu;
  assign WGPIOPD   = r_pd;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahbl_gpio_ctrl
// Description : Self-checking bench for ahbl_gpio_ctrl. Register write/readback
//               vectors from a table, then hand-built sequences for reset,
//               ignored transfers, synchroniser latency and interrupt timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_gpio_ctrl;

  localparam logic [15:0] c_RESET_DIR = 16'h5A3C;

  localparam logic [2:0] c_DATA  = 3'd0;
  localparam logic [2:0] c_DIR   = 3'd1;
  localparam logic [2:0] c_PU    = 3'd2;
  localparam logic [2:0] c_PD    = 3'd3;
  localparam logic [2:0] c_IM    = 3'd4;
  localparam logic [2:0] c_IEDGE = 3'd5;
  localparam logic [2:0] c_RIS   = 3'd6;
  localparam logic [2:0] c_MIS   = 3'd7;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        IRQ;
  logic [15:0] WGPIODIN;
  logic [15:0] WGPIODOUT;
  logic [15:0] WGPIODIR;
  logic [15:0] WGPIOPU;
  logic [15:0] WGPIOPD;

  ahbl_gpio_ctrl #(
    .SYNC_STAGES (2),
    .RESET_DIR   (c_RESET_DIR)
  ) u_dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .IRQ       (IRQ),
    .WGPIODIN  (WGPIODIN),
    .WGPIODOUT (WGPIODOUT),
    .WGPIODIR  (WGPIODIR),
    .WGPIOPU   (WGPIOPU),
    .WGPIOPD   (WGPIOPD)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive an address phase (no clock wait).
  task automatic drv(input logic valid, input logic wr, input logic [2:0] off);
    HSEL   = valid;
    HTRANS = valid ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = {27'h0, off, 2'b00};
  endtask

  // Write: returns just after the edge that ends the data phase.
  task automatic ahb_write(input logic [2:0] off, input logic [31:0] d);
    @(negedge HCLK);
    drv(1'b1, 1'b1, off);
    @(posedge HCLK);
    @(negedge HCLK);
    HWDATA = d;
    drv(1'b0, 1'b0, c_DATA);
    @(posedge HCLK);
  endtask

  // Read: returns at the falling edge inside the data phase with HRDATA sampled.
  task automatic ahb_read(input logic [2:0] off, output logic [31:0] d);
    @(negedge HCLK);
    drv(1'b1, 1'b0, off);
    @(posedge HCLK);
    @(negedge HCLK);
    drv(1'b0, 1'b0, c_DATA);
    d = HRDATA;
  endtask

  // Write attempt with a non-qualifying address phase: must not change DOUT.
  task automatic ignored_write(input string name, input logic s, input logic [1:0] t,
                               input logic r);
    @(negedge HCLK);
    HSEL = s; HTRANS = t; HREADY = r; HWRITE = 1'b1; HADDR = 32'h0;
    @(posedge HCLK);
    @(negedge HCLK);
    HWDATA = 32'h0000_FFFF;
    HREADY = 1'b1;
    drv(1'b0, 1'b0, c_DATA);
    @(posedge HCLK);
    @(negedge HCLK);
    chk(name, {16'h0, WGPIODOUT}, 32'h0000_A5A5);
  endtask

  typedef struct {
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [15:0] exp_rd;
    int          sel;      // 0 DOUT, 1 DIR, 2 PU, 3 PD, other = no wrapper port
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [15:0] port_val(input int sel);
    case (sel)
      0:       return WGPIODOUT;
      1:       return WGPIODIR;
      2:       return WGPIOPU;
      default: return WGPIOPD;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    // DATA readback is the synchronised pad input (held at 0), not DOUT.
    vecs[0] = '{c_DATA,  32'hDEAD_A5A5, 16'h0000, 0, 16'hA5A5};
    vecs[1] = '{c_DIR,   32'h1234_00FF, 16'h00FF, 1, 16'h00FF};
    vecs[2] = '{c_PU,    32'hFFFF_0F0F, 16'h0F0F, 2, 16'h0F0F};
    vecs[3] = '{c_PD,    32'h0000_F0F0, 16'hF0F0, 3, 16'hF0F0};
    vecs[4] = '{c_IM,    32'hFFFF_00F0, 16'h00F0, 9, 16'h0000};
    vecs[5] = '{c_IEDGE, 32'h8000_3C3C, 16'h3C3C, 9, 16'h0000};

    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = 32'h0; HREADY = 1'b1; WGPIODIN = 16'h0000;

    // ---------------- reset state ----------------
    repeat (3) @(negedge HCLK);
    chk("rst_dout",  {16'h0, WGPIODOUT}, 32'h0);
    chk("rst_dir",   {16'h0, WGPIODIR},  {16'h0, c_RESET_DIR});
    chk("rst_pu",    {16'h0, WGPIOPU},   32'h0);
    chk("rst_pd",    {16'h0, WGPIOPD},   32'h0);
    chk("rst_irq",   {31'h0, IRQ},       32'h0);
    chk("rst_hrdata", HRDATA,            32'h0);
    chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("hresp",     {31'h0, HRESP},     32'h0);
    HRESETn = 1'b1;

    // ---------------- table: write, back-to-back readback ----------------
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      drv(1'b1, 1'b1, vecs[i].off);
      @(posedge HCLK);
      @(negedge HCLK);
      HWDATA = vecs[i].wdata;
      drv(1'b1, 1'b0, vecs[i].off);
      @(posedge HCLK);
      @(negedge HCLK);
      drv(1'b0, 1'b0, c_DATA);
      chk($sformatf("rdback_%0d", i), HRDATA, {16'h0, vecs[i].exp_rd});
      if (vecs[i].sel < 4)
        chk($sformatf("port_%0d", i), {16'h0, port_val(vecs[i].sel)}, {16'h0, vecs[i].exp_out});
    end

    // ---------------- non-qualifying transfers ----------------
    ignored_write("ign_busy",   1'b1, 2'b01, 1'b1);
    ignored_write("ign_nosel",  1'b0, 2'b10, 1'b1);
    ignored_write("ign_nordy",  1'b1, 2'b10, 1'b0);

    // ---------------- asynchronous reset mid-write ----------------
    @(negedge HCLK);
    drv(1'b1, 1'b1, c_DIR);
    @(posedge HCLK);
    @(negedge HCLK);
    HWDATA = 32'h0000_1111;
    drv(1'b0, 1'b0, c_DATA);
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_rst_dout", {16'h0, WGPIODOUT}, 32'h0);
    chk("mid_rst_dir",  {16'h0, WGPIODIR},  {16'h0, c_RESET_DIR});
    chk("mid_rst_pu",   {16'h0, WGPIOPU},   32'h0);
    chk("mid_rst_pd",   {16'h0, WGPIOPD},   32'h0);
    chk("mid_rst_irq",  {31'h0, IRQ},       32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    ahb_read(c_DIR, rd);
    chk("post_rst_dir", rd, {16'h0, c_RESET_DIR});
    ahb_read(c_IEDGE, rd);
    chk("post_rst_iedge", rd, 32'h0);

    // ---------------- input synchroniser ----------------
    ahb_write(c_IEDGE, 32'h3C3C);
    ahb_write(c_IM, 32'h00F0);
    @(negedge HCLK);
    WGPIODIN = 16'h1234;
    drv(1'b1, 1'b0, c_DATA);
    @(posedge HCLK);                       // edge k: read address captured
    @(negedge HCLK);
    chk("sync_k", HRDATA, 32'h0);
    drv(1'b1, 1'b0, c_DATA);
    @(posedge HCLK);                       // edge k+1
    @(negedge HCLK);
    chk("sync_k1", HRDATA, 32'h1234);
    drv(1'b0, 1'b0, c_DATA);
    repeat (3) @(negedge HCLK);
    ahb_read(c_RIS, rd);
    chk("sync_ris", rd, 32'h1034);         // 0x1234 rises & IEDGE 0x3C3C
    ahb_read(c_MIS, rd);
    chk("sync_mis", rd, 32'h0030);
    chk("sync_irq", {31'h0, IRQ}, 32'h1);
    ahb_write(c_IM, 32'h0);
    ahb_write(c_RIS, 32'hFFFF);
    @(negedge HCLK);
    @(negedge HCLK);
    chk("clr_irq", {31'h0, IRQ}, 32'h0);
    ahb_read(c_RIS, rd);
    chk("clr_ris", rd, 32'h0);

    // ---------------- rising interrupt on pin 0 ----------------
    ahb_write(c_IEDGE, 32'h0001);
    ahb_write(c_IM, 32'h0001);
    @(negedge HCLK);
    WGPIODIN = 16'h1235;
    @(posedge HCLK);                       // k
    @(negedge HCLK);
    chk("rise_irq_k", {31'h0, IRQ}, 32'h0);
    drv(1'b1, 1'b0, c_RIS);
    @(posedge HCLK);                       // k+1
    @(negedge HCLK);
    chk("rise_ris_k1", HRDATA, 32'h0);
    chk("rise_irq_k1", {31'h0, IRQ}, 32'h0);
    drv(1'b1, 1'b0, c_RIS);
    @(posedge HCLK);                       // k+2
    @(negedge HCLK);
    chk("rise_ris_k2", HRDATA, 32'h1);
    chk("rise_irq_k2", {31'h0, IRQ}, 32'h0);
    drv(1'b1, 1'b0, c_MIS);
    @(posedge HCLK);                       // k+3
    @(negedge HCLK);
    chk("rise_mis", HRDATA, 32'h1);
    chk("rise_irq_k3", {31'h0, IRQ}, 32'h1);
    drv(1'b0, 1'b0, c_DATA);
    ahb_write(c_RIS, 32'h0001);            // RIS clears at this edge
    @(negedge HCLK);
    chk("w1c_irq_same", {31'h0, IRQ}, 32'h1);
    @(negedge HCLK);
    chk("w1c_irq_next", {31'h0, IRQ}, 32'h0);

    // ---------------- falling interrupt, masked then unmasked ----------------
    ahb_write(c_IEDGE, 32'h0000);
    ahb_write(c_IM, 32'h0000);
    @(negedge HCLK);
    WGPIODIN = 16'h123D;                   // pin3 rises: no event
    repeat (5) @(negedge HCLK);
    WGPIODIN = 16'h1235;                   // pin3 falls
    repeat (5) @(negedge HCLK);
    ahb_read(c_RIS, rd);
    chk("fall_ris", rd, 32'h0008);
    chk("fall_irq_masked", {31'h0, IRQ}, 32'h0);
    ahb_write(c_IM, 32'h0008);
    @(negedge HCLK);
    chk("unmask_irq_same", {31'h0, IRQ}, 32'h0);
    @(negedge HCLK);
    chk("unmask_irq_next", {31'h0, IRQ}, 32'h1);
    ahb_read(c_MIS, rd);
    chk("fall_mis", rd, 32'h0008);

    // ---------------- W1C colliding with a new set ----------------
    ahb_write(c_IEDGE, 32'h0001);
    ahb_write(c_IM, 32'h0001);
    @(negedge HCLK);
    WGPIODIN = 16'h1234;
    repeat (5) @(negedge HCLK);
    WGPIODIN = 16'h1235;
    repeat (5) @(negedge HCLK);
    chk("coll_pre_irq", {31'h0, IRQ}, 32'h1);
    WGPIODIN = 16'h1234;
    repeat (5) @(negedge HCLK);
    WGPIODIN = 16'h1235;
    @(posedge HCLK);                       // k
    @(negedge HCLK);
    drv(1'b1, 1'b1, c_RIS);
    @(posedge HCLK);                       // k+1
    @(negedge HCLK);
    HWDATA = 32'h0000_0001;
    drv(1'b1, 1'b0, c_RIS);
    @(posedge HCLK);                       // k+2: clear and set together
    @(negedge HCLK);
    chk("coll_ris", HRDATA, 32'h0009);
    chk("coll_irq_k2", {31'h0, IRQ}, 32'h1);
    drv(1'b0, 1'b0, c_DATA);
    @(negedge HCLK);
    chk("coll_irq_k3", {31'h0, IRQ}, 32'h1);
    @(negedge HCLK);
    chk("coll_irq_k4", {31'h0, IRQ}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
